// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types and constants for the multi-cycle data-memory responder
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_resp_state_t;

  localparam int MAX_WAIT_CYCLES = 15;

  // Counter preload for a given wait-state count, clamped into the 4-bit counter's legal range.
  function automatic logic [3:0] wait_load(input int wait_cycles);
    int w;
    w = wait_cycles;
    if (w > MAX_WAIT_CYCLES) w = MAX_WAIT_CYCLES;
    if (w < 1) w = 1;
    return 4'(w - 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage data-memory port between the pipeline and the responder
interface data_mem_responder_if #(
  parameter int WORD_LEN = 8,
  parameter int ADDR_LEN = 8
);
  logic                MemRead;
  logic                MemWrite;
  logic [ADDR_LEN-1:0] Address;
  logic [WORD_LEN-1:0] WriteData;
  logic [WORD_LEN-1:0] ReadData;
  logic                mem_busy;
  logic                rd_valid;
  logic                req_err;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, mem_busy, rd_valid, req_err
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, mem_busy, rd_valid, req_err
  );
endinterface

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with synchronous write and registered, load-enabled read
module data_mem_array #(
  parameter int WORD_LEN = 8,
  parameter int ADDR_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] rdata
);

  logic [WORD_LEN-1:0] mem [2**ADDR_LEN];

  // Storage is deliberately not reset so contents survive an aborted access.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data memory that stalls the pipeline via mem_busy
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WORD_LEN    = 8,
  parameter int ADDR_LEN    = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  data_mem_responder_if.slave        bus
);

  localparam logic [3:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  mem_resp_state_t     state, state_nxt;
  logic [3:0]          cnt;
  logic                op_write;
  logic [ADDR_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic                req_err_q;
  logic                valid_req, both_req;
  logic                accept, access, busy;

  assign valid_req = bus.MemRead ^ bus.MemWrite;
  assign both_req  = bus.MemRead & bus.MemWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (valid_req) begin
          accept    = 1'b1;
          busy      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      // The CPU still holds its request here; it leaves MEM at this edge, so it must not be re-accepted.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      op_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_err_q <= 1'b0;
    end else begin
      if (accept) begin
        op_write <= bus.MemWrite;
        addr_q   <= bus.Address;
        wdata_q  <= bus.WriteData;
        cnt      <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == IDLE && both_req) req_err_q <= 1'b1;
    end
  end

  data_mem_array #(
    .WORD_LEN (WORD_LEN),
    .ADDR_LEN (ADDR_LEN)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (access & op_write),
    .re    (access & ~op_write),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (bus.ReadData)
  );

  assign bus.mem_busy = busy;
  assign bus.rd_valid = (state == DONE) & ~op_write;
  assign bus.req_err  = req_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
  import mem_resp_pkg::*;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.WORD_LEN(8), .ADDR_LEN(8)) bus ();

  data_mem_responder #(.WORD_LEN(8), .ADDR_LEN(8), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];

  // Drives one request from a negedge, holds it through DONE, clears it at the following negedge.
  task automatic access(input bit wr, input logic [7:0] addr, input logic [7:0] data, input bit corrupt);
    int busy_cycles;
    bit done;
    logic [7:0] exp;
    busy_cycles = 0;
    done = 0;
    bus.MemWrite = wr;
    bus.MemRead = !wr;
    bus.Address = addr;
    bus.WriteData = data;
    if (wr) model[addr] = data;
    else exp_q.push_back(model[addr]);
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (c == 0) begin
        checks++;
        if (dut.state !== IDLE) begin
          failures++;
          $display("FAIL accept_state addr=%h: got %0d expected %0d", addr, dut.state, IDLE);
        end
      end
      if (bus.mem_busy === 1'b1) begin
        busy_cycles++;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
          failures++;
          $display("FAIL rd_valid_while_busy cycle=%0d: got %b expected 0", c, bus.rd_valid);
        end
      end else begin
        done = 1;
        checks++;
        if (c != W + 1 || dut.state !== DONE) begin
          failures++;
          $display("FAIL done_timing addr=%h: got cycle=%0d state=%0d expected cycle=%0d state=%0d", addr, c, dut.state, W + 1, DONE);
        end
        checks++;
        if (bus.rd_valid !== !wr) begin
          failures++;
          $display("FAIL rd_valid_done wr=%0d: got %b expected %b", wr, bus.rd_valid, !wr);
        end
        if (!wr) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got load result %h expected a queued value", bus.ReadData);
          end else begin
            exp = exp_q.pop_front();
            if (bus.ReadData !== exp) begin
              failures++;
              $display("FAIL read_data addr=%h: got %h expected %h", addr, bus.ReadData, exp);
            end
          end
        end
      end
      if (!done) begin
        @(negedge clk);
        if (corrupt) begin
          bus.Address = 8'h20;
          bus.WriteData = 8'hFF;
        end
      end
    end
    checks++;
    if (!done || busy_cycles != W + 1) begin
      failures++;
      $display("FAIL busy_cycles addr=%h: got %0d (done=%0d) expected %0d", addr, busy_cycles, done, W + 1);
    end
    @(negedge clk);
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Address = '0;
    bus.WriteData = '0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.ReadData !== 8'h00 || bus.mem_busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.req_err !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%h busy=%b rv=%b err=%b st=%0d expected all 0", bus.ReadData, bus.mem_busy, bus.rd_valid, bus.req_err, dut.state);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store;
    access(1'b1, 8'h10, 8'h5A, 1'b0);
    #1;
    checks++;
    if (dut.state !== IDLE || bus.mem_busy !== 1'b0) begin
      failures++;
      $display("FAIL store_return_idle: got state=%0d busy=%b expected %0d 0", dut.state, bus.mem_busy, IDLE);
    end
    @(negedge clk);
  endtask

  task automatic test_load;
    access(1'b0, 8'h10, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.ReadData !== 8'h5A || bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_hold: got rd=%h rv=%b expected 5a 0", bus.ReadData, bus.rd_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_change;
    access(1'b1, 8'h20, 8'hC3, 1'b0);
    access(1'b1, 8'h11, 8'h33, 1'b1);
    access(1'b0, 8'h11, 8'h00, 1'b0);
    access(1'b0, 8'h20, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    access(1'b1, 8'h30, 8'h01, 1'b0);
    access(1'b0, 8'h30, 8'h00, 1'b0);
    access(1'b1, 8'h31, 8'h9C, 1'b0);
    access(1'b0, 8'h31, 8'h00, 1'b0);
  endtask

  task automatic test_req_err;
    bus.MemRead = 1'b1;
    bus.MemWrite = 1'b1;
    bus.Address = 8'h10;
    bus.WriteData = 8'hEE;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.mem_busy !== 1'b0 || dut.state !== IDLE) begin
        failures++;
        $display("FAIL both_req_busy cycle=%0d: got busy=%b state=%0d expected 0 %0d", c, bus.mem_busy, dut.state, IDLE);
      end
      @(negedge clk);
    end
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_err !== 1'b1) begin
      failures++;
      $display("FAIL req_err_sticky: got %b expected 1", bus.req_err);
    end
    @(negedge clk);
    access(1'b0, 8'h10, 8'h00, 1'b0);
    #1;
    checks++;
    if (bus.req_err !== 1'b1) begin
      failures++;
      $display("FAIL req_err_after_access: got %b expected 1", bus.req_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    access(1'b1, 8'h40, 8'hAB, 1'b0);
    access(1'b0, 8'h11, 8'h00, 1'b0);
    bus.MemWrite = 1'b1;
    bus.Address = 8'h40;
    bus.WriteData = 8'h77;
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== WAIT) begin
      failures++;
      $display("FAIL abort_setup_state: got %0d expected %0d", dut.state, WAIT);
    end
    rst = 1'b0;
    bus.MemWrite = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.ReadData !== 8'h00 || bus.mem_busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.req_err !== 1'b0) begin
        failures++;
        $display("FAIL outputs_in_reset cycle=%0d: got rd=%h busy=%b rv=%b err=%b expected all 0", c, bus.ReadData, bus.mem_busy, bus.rd_valid, bus.req_err);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 8'h40, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wait_change();
    test_back_to_back();
    test_req_err();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
